// File: rtl/ecg_pkg.sv
// Shared defaults and state encoding for the ECG front-end blocks.
package ecg_pkg;

    localparam int IN_W_DEF      = 16;
    localparam int OUT_W_DEF     = 8;
    localparam int SHIFT_DEF     = 4;
    localparam int N_SAMPLES_DEF = 256;
    localparam int ADDR_W_DEF    = 8;

    typedef enum logic {
        LOAD = 1'b0,
        DONE = 1'b1
    } ecg_state_e;

endpackage

// File: rtl/ecg_sat_scale.sv
// Arithmetic right shift followed by saturation into a narrower signed word.
// Purely combinational so later filter stages can drop it into their own
// pipelines wherever they need it.
module ecg_sat_scale
    import ecg_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int SHIFT = SHIFT_DEF
) (
    input  logic [IN_W-1:0]  data_i,
    output logic [OUT_W-1:0] data_o
);

    logic signed [IN_W-1:0] shifted_w;

    // Arithmetic shift: negative values round toward -inf.
    assign shifted_w = $signed(data_i) >>> SHIFT;

    if (OUT_W >= IN_W) begin : gen_wide
        // Output is wide enough for every shifted value; just sign-extend.
        assign data_o = OUT_W'(shifted_w);
    end else begin : gen_sat
        localparam logic signed [IN_W-1:0] MAX_V = IN_W'(2 ** (OUT_W - 1) - 1);
        localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;

        // Clamp to the representable range of the output word.
        always_comb begin
            if (shifted_w > MAX_V) begin
                data_o = MAX_V[OUT_W-1:0];
            end else if (shifted_w < MIN_V) begin
                data_o = MIN_V[OUT_W-1:0];
            end else begin
                data_o = shifted_w[OUT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ecg_sample_loader.sv
// Feeds one window of scaled ECG samples into the BNN sample buffer, then
// hands the window over with ecg_rd_done and waits for bnn_done.
//
// state | meaning
// ------+---------------------------------------------------------------
// LOAD  | s_ready high; each accepted sample is written one cycle later
// DONE  | window complete; ecg_rd_done held until bnn_done is sampled
module ecg_sample_loader
    import ecg_pkg::*;
#(
    parameter int IN_W      = IN_W_DEF,
    parameter int OUT_W     = OUT_W_DEF,
    parameter int SHIFT     = SHIFT_DEF,
    parameter int N_SAMPLES = N_SAMPLES_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [IN_W-1:0]   s_data,
    output logic              s_ready,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [OUT_W-1:0]  buf_wdata,
    output logic              ecg_rd_done,
    input  logic              bnn_done,
    output logic [15:0]       frame_cnt
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_SAMPLES - 1);

    ecg_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [OUT_W-1:0]  wdata_q, wdata_d;
    logic              done_q, done_d;
    logic [15:0]       frame_q, frame_d;

    logic [OUT_W-1:0]  scaled_w;
    logic              accept_w;

    ecg_sat_scale #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_sat_scale (
        .data_i (s_data),
        .data_o (scaled_w)
    );

    // s_ready is registered, so it already encodes "state is LOAD and we are
    // out of reset"; no separate state term is needed here.
    assign accept_w = s_valid && ready_q;

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        frame_d = frame_q;

        case (state_q)
            LOAD: begin
                ready_d = 1'b1;
                if (accept_w) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q;
                    wdata_d = scaled_w;
                    if (cnt_q == LAST_IDX) begin
                        // Last sample: the final write and ecg_rd_done appear
                        // together; bnn_done on this edge is not looked at.
                        cnt_d   = '0;
                        state_d = DONE;
                        ready_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            DONE: begin
                ready_d = 1'b0;
                done_d  = 1'b1;
                if (bnn_done) begin
                    state_d = LOAD;
                    ready_d = 1'b1;
                    done_d  = 1'b0;
                    frame_d = frame_q + 16'd1;
                end
            end
            default: begin
                state_d = LOAD;
                ready_d = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            frame_q <= frame_d;
        end
    end

    assign s_ready     = ready_q;
    assign buf_we      = we_q;
    assign buf_addr    = addr_q;
    assign buf_wdata   = wdata_q;
    assign ecg_rd_done = done_q;
    assign frame_cnt   = frame_q;

endmodule

// File: tb/tb_ecg_sample_loader.sv
// Scoreboard bench for ecg_sample_loader.
module tb_ecg_sample_loader;

    localparam int N = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic [15:0]       s_data;
    logic              s_ready;
    logic              buf_we;
    logic [7:0]        buf_addr;
    logic signed [7:0] buf_wdata;
    logic              ecg_rd_done;
    logic              bnn_done;
    logic [15:0]       frame_cnt;

    ecg_sample_loader #(
        .IN_W      (16),
        .OUT_W     (8),
        .SHIFT     (4),
        .N_SAMPLES (N),
        .ADDR_W    (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .buf_we      (buf_we),
        .buf_addr    (buf_addr),
        .buf_wdata   (buf_wdata),
        .ecg_rd_done (ecg_rd_done),
        .bnn_done    (bnn_done),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    typedef struct {
        int addr;
        int data;
    } exp_t;

    exp_t sb_q[$];
    int   exp_cnt;

    function automatic int sat_model(input logic [15:0] d);
        int v;
        v = int'($signed(d)) >>> 4;
        if (v > 127) v = 127;
        else if (v < -128) v = -128;
        return v;
    endfunction

    // One input cycle: entered and left at posedge+1.
    task automatic drive(input logic v, input logic [15:0] d, output logic acc);
        s_valid = v;
        s_data  = d;
        @(negedge clk);
        acc = v && s_ready;
        @(posedge clk);
        if (acc) begin
            sb_q.push_back('{exp_cnt, sat_model(d)});
            exp_cnt = (exp_cnt + 1) % N;
        end
        #1;
    endtask

    task automatic send(input int n, input bit rand_v, input bit rand_d,
                        input logic [15:0] fixed, output int cycles);
        int   sent;
        logic acc;
        logic v;
        logic [15:0] d;
        sent   = 0;
        cycles = 0;
        while (sent < n && cycles < n * 8 + 20) begin
            v = rand_v ? 1'($urandom_range(0, 1)) : 1'b1;
            d = rand_d ? 16'($urandom) : fixed;
            drive(v, d, acc);
            if (acc) sent++;
            cycles++;
        end
        s_valid = 1'b0;
        chk("send_count", sent, n);
    endtask

    task automatic wait_done(input int limit);
        int i;
        i = 0;
        while (!ecg_rd_done && i < limit) begin
            @(posedge clk);
            #1;
            i++;
        end
        chk("done_seen", int'(ecg_rd_done), 1);
    endtask

    task automatic release_frame(input int delay, input int exp_frame);
        repeat (delay) begin
            @(posedge clk);
            #1;
        end
        chk("rel_still_done", int'(ecg_rd_done), 1);
        bnn_done = 1'b1;
        @(posedge clk);
        #1;
        bnn_done = 1'b0;
        chk("rel_done_low", int'(ecg_rd_done), 0);
        chk("rel_frame", int'(frame_cnt), exp_frame);
        chk("rel_ready", int'(s_ready), 1);
    endtask

    task automatic apply_reset(input int cycles);
        rst      = 1'b1;
        s_valid  = 1'b0;
        bnn_done = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
        sb_q.delete();
        exp_cnt = 0;
        rst     = 1'b0;
    endtask

    // Output monitor: every write must match the oldest expected entry.
    int   win_writes = 0;
    logic prev_done  = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            win_writes = 0;
            prev_done  = 1'b0;
        end else begin
            if (buf_we) begin
                win_writes++;
                if (sb_q.size() == 0) begin
                    chk("spurious_we", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("wr_addr", int'(buf_addr), e.addr);
                    chk("wr_data", int'(buf_wdata), e.data);
                end
            end
            if (ecg_rd_done && !prev_done) begin
                chk("done_with_we", int'(buf_we), 1);
                chk("done_addr", int'(buf_addr), N - 1);
                chk("win_writes", win_writes, N);
                win_writes = 0;
            end
            prev_done = ecg_rd_done;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] sw[5];
        int          sw_exp[5];
        int          cyc;
        int          bad;
        logic        acc;

        sw     = '{16'h7FFF, 16'h8000, 16'd2047, 16'hF800, 16'hFFFF};
        sw_exp = '{127, -128, 127, -128, -1};

        rst      = 1'b1;
        s_valid  = 1'b0;
        s_data   = '0;
        bnn_done = 1'b0;
        exp_cnt  = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("rst_ready", int'(s_ready), 0);
        chk("rst_we", int'(buf_we), 0);
        chk("rst_addr", int'(buf_addr), 0);
        chk("rst_wdata", int'(buf_wdata), 0);
        chk("rst_done", int'(ecg_rd_done), 0);
        chk("rst_frame", int'(frame_cnt), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", int'(s_ready), 1);

        // Back-to-back window of 32 -> wdata 2.
        send(N, 1'b0, 1'b0, 16'd32, cyc);
        chk("t1_cycles", cyc, N);
        chk("t1_done", int'(ecg_rd_done), 1);
        chk("t1_last_addr", int'(buf_addr), N - 1);
        chk("t1_last_wdata", int'(buf_wdata), 2);
        chk("t1_ready", int'(s_ready), 0);

        // Long hold in DONE with s_valid high.
        bad = 0;
        repeat (1000) begin
            drive(1'b1, 16'h1234, acc);
            if (acc || !ecg_rd_done || s_ready || buf_we) bad++;
        end
        s_valid = 1'b0;
        chk("t3_hold_bad", bad, 0);
        release_frame(0, 1);

        // Fresh start for the random/saturation windows.
        apply_reset(2);
        chk("frame_after_rst", int'(frame_cnt), 0);

        for (int i = 0; i < 5; i++) begin
            send(1, 1'b0, 1'b0, sw[i], cyc);
            chk($sformatf("sat_%0d", i), int'(buf_wdata), sw_exp[i]);
        end
        send(N - 5, 1'b1, 1'b1, 16'h0, cyc);
        wait_done(50);
        release_frame(20, 1);
        for (int w = 2; w <= 3; w++) begin
            send(N, 1'b1, 1'b1, 16'h0, cyc);
            wait_done(50);
            release_frame(20, w);
        end
        chk("t4_frame", int'(frame_cnt), 3);

        // Reset in the middle of a window.
        send(100, 1'b1, 1'b1, 16'h0, cyc);
        drive(1'b0, 16'h0, acc);
        chk("t5_sb_empty", sb_q.size(), 0);
        apply_reset(1);
        chk("t5_done_rst", int'(ecg_rd_done), 0);
        chk("t5_addr_rst", int'(buf_addr), 0);
        chk("t5_frame_rst", int'(frame_cnt), 0);
        send(N, 1'b1, 1'b1, 16'h0, cyc);
        wait_done(50);
        chk("t5_frame_pre", int'(frame_cnt), 0);
        release_frame(20, 1);

        // bnn_done high throughout LOAD and on the final accept.
        bnn_done = 1'b1;
        send(N, 1'b0, 1'b1, 16'h0, cyc);
        chk("t6_done", int'(ecg_rd_done), 1);
        chk("t6_frame_hold", int'(frame_cnt), 1);
        @(posedge clk);
        #1;
        chk("t6_done_low", int'(ecg_rd_done), 0);
        chk("t6_frame", int'(frame_cnt), 2);
        chk("t6_ready", int'(s_ready), 1);
        bnn_done = 1'b0;

        drive(1'b0, 16'h0, acc);
        drive(1'b0, 16'h0, acc);
        chk("final_sb_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ecg_sample_loader.md
Name: ecg_sample_loader

Overview:
- Upstream feeder for the BNN accelerator top.
- Accepts a stream of raw signed ECG samples over a valid/ready handshake.
- Rescales and saturates each sample to the accelerator's input width, then writes one window of N_SAMPLES into the accelerator's sample buffer.
- Raises ecg_rd_done, holds it until the accelerator reports done, then loads the next window.

Parameters:
- IN_W, 16, raw sample width (signed two's complement).
- OUT_W, 8, buffer word width (signed).
- SHIFT, 4, arithmetic right shift applied before saturation (0..IN_W-1).
- N_SAMPLES, 256, samples per window.
- ADDR_W, 8, buffer address width; must satisfy 2**ADDR_W >= N_SAMPLES.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- s_valid  in  1  input sample valid.
- s_data  in  IN_W  raw signed ECG sample.
- s_ready  out  1  loader can accept a sample this cycle.
- buf_we  out  1  sample buffer write enable.
- buf_addr  out  ADDR_W  sample buffer write address.
- buf_wdata  out  OUT_W  scaled, saturated sample.
- ecg_rd_done  out  1  window complete; level start to the accelerator.
- bnn_done  in  1  accelerator finished classifying the current window.
- frame_cnt  out  16  number of completed windows.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values (applied on the first edge with rst=1): state=LOAD, s_ready=0, buf_we=0, buf_addr=0, buf_wdata=0, ecg_rd_done=0, frame_cnt=0, sample counter=0. s_ready rises the first cycle after rst falls.
- States:
  - LOAD: s_ready=1. Each cycle with s_valid&&s_ready is an accepted sample.
  - DONE: s_ready=0, ecg_rd_done=1.
- Write path, one cycle of latency: an accepted sample at edge k produces buf_we=1, buf_addr=cnt, buf_wdata=sat(s_data>>>SHIFT) during the cycle after edge k. buf_we is 0 in every cycle without an accepted sample in the previous cycle.
- Saturation: result = shifted value clamped to [-(2**(OUT_W-1)), 2**(OUT_W-1)-1], i.e. [-128, 127] by default. The shift is arithmetic, so negative values round toward -inf.
- Counter: cnt increments per accepted sample.
  - On the accept with cnt==N_SAMPLES-1: cnt wraps to 0 and the state goes to DONE.
  - ecg_rd_done rises in the same cycle the last buf_we is presented.
- DONE exit:
  - ecg_rd_done stays high until bnn_done is sampled high.
  - On that edge: ecg_rd_done drops, frame_cnt increments (wraps at 16'hFFFF→0), and the state returns to LOAD. s_ready=1 in the next cycle.
- bnn_done while in LOAD is ignored. s_valid while in DONE is not accepted; the upstream holds data per standard valid/ready rules.
- bnn_done coinciding with the last accept of a window is ignored, because the state is still LOAD.
- rst asserted mid-window or in DONE: all state is discarded. The partial window is not completed and ecg_rd_done drops on that edge.
- No sample is written twice or dropped; within a window buf_addr is strictly sequential from 0 to N_SAMPLES-1.

Decomposition:
- Shared package ecg_pkg: IN_W, OUT_W, N_SAMPLES, ADDR_W defaults, and a state enum {LOAD, DONE}.
- Sub-module ecg_sat_scale (purely combinational shift+saturate, parameterised IN_W/OUT_W/SHIFT). It is reused by later filter stages.

Test Plan:
- Reset then 256 back-to-back samples of value 16'sd32:
  - buf_we high for 256 consecutive cycles, addresses 0..255, wdata=2.
  - ecg_rd_done rises with addr 255; s_ready=0 afterwards.
- Saturation sweep with s_data = 16'sh7FFF, 16'sh8000, 16'sd2047, -16'sd2048, -16'sd1:
  - Required wdata 127, -128, 127, -128, -1.
- Hold in DONE with bnn_done low for 1000 cycles, s_valid=1:
  - ecg_rd_done stays 1, no buf_we, s_ready=0.
  - A 1-cycle bnn_done pulse then gives ecg_rd_done=0, frame_cnt=1, and s_ready=1 next cycle.
- Random s_valid (50% duty) over 3 windows, with bnn_done returned 20 cycles after each ecg_rd_done:
  - Scoreboard matches every written word to its input in order.
  - frame_cnt=3.
- rst asserted after 100 samples, then a full window:
  - After reset, addresses restart at 0, exactly 256 writes precede ecg_rd_done, frame_cnt=0 until the first bnn_done.
- bnn_done high continuously during LOAD and on the final accept:
  - No early exit; ecg_rd_done asserts.
  - The next edge with bnn_done=1 in DONE completes the frame.
